// File: rtl/irq_agg3_pkg.sv
// irq_agg3_pkg: line ids, line count and a one-hot helper shared by irq_agg3 and its interface
package irq_agg3_pkg;
  typedef logic [1:0] line_id_t;
  localparam line_id_t ID_A    = 2'd0;
  localparam line_id_t ID_B    = 2'd1;
  localparam line_id_t ID_C    = 2'd2;
  localparam line_id_t ID_NONE = 2'd3;
  localparam int NUM_LINES = 3;
  function automatic logic [NUM_LINES-1:0] id_onehot(input line_id_t id);
    return (id == ID_NONE) ? '0 : NUM_LINES'(1) << id;
  endfunction
endpackage

// File: rtl/irq_agg3_if.sv
// irq_agg3_if: event lines, mask and id/ready handshake of irq_agg3
interface irq_agg3_if
  import irq_agg3_pkg::*;
#(parameter int CNT_W = 4);
  logic             a;
  logic             b;
  logic             c;
  logic [2:0]       mask;
  logic             out_ready;
  logic             y;
  logic             out_valid;
  line_id_t         out_id;
  logic [CNT_W-1:0] lost_cnt;
  modport master(output a, b, c, mask, out_ready, input y, out_valid, out_id, lost_cnt);
  modport slave(input a, b, c, mask, out_ready, output y, out_valid, out_id, lost_cnt);
endinterface

// File: rtl/irq_agg3_edge_det.sv
// irq_agg3_edge_det: optional 2-flop synchronizer (IRQ_AGG3_SYNC_EN), prev-sample register, rise pulse
module irq_agg3_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);
  logic smp;
  logic prev;
`ifdef IRQ_AGG3_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else sync <= {sync[0], sig};
  end
  assign smp = sync[1];
`else
  assign smp = sig;
`endif
  // prev resets high so a line already high at reset release is not an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else prev <= smp;
  end
  assign rise = smp & ~prev;
endmodule

// File: rtl/irq_agg3.sv
// irq_agg3: three-line rising-edge interrupt aggregator with masking, priority id handshake and saturating loss count (IRQ_AGG3_SYNC_EN adds input synchronizers)
module irq_agg3
  import irq_agg3_pkg::*;
#(parameter int CNT_W = 4) (
  input logic       clk,
  input logic       rst_n,
  irq_agg3_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [NUM_LINES-1:0] lines;
  logic [NUM_LINES-1:0] rise;
  logic [NUM_LINES-1:0] pending;
  logic [NUM_LINES-1:0] pending_n;
  logic [NUM_LINES-1:0] vis;
  logic [NUM_LINES-1:0] clr;
  logic [NUM_LINES-1:0] lost;
  logic [1:0]           n_lost;
  logic [CNT_W+1:0]     sum;
  logic [CNT_W-1:0]     cnt;
  assign lines = {bus.c, bus.b, bus.a};
  for (genvar i = 0; i < NUM_LINES; i++) begin : g_det
    irq_agg3_edge_det u_det (.clk(clk), .rst_n(rst_n), .sig(lines[i]), .rise(rise[i]));
  end
  always_comb begin
    vis           = pending & ~bus.mask;
    bus.y         = |vis;
    bus.out_valid = |vis;
    bus.out_id    = vis[0] ? ID_A : vis[1] ? ID_B : vis[2] ? ID_C : ID_NONE;
    bus.lost_cnt  = cnt;
    clr           = (bus.out_valid && bus.out_ready) ? id_onehot(bus.out_id) : '0;
    // a new edge beats a same-cycle clear and is not a loss
    lost          = rise & pending & ~clr;
    pending_n     = (pending & ~clr) | rise;
    n_lost        = 2'(lost[0]) + 2'(lost[1]) + 2'(lost[2]);
    sum           = (CNT_W+2)'(cnt) + (CNT_W+2)'(n_lost);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      cnt     <= '0;
    end else begin
      pending <= pending_n;
      cnt     <= (sum > (CNT_W+2)'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_irq_agg3.sv
// tb_irq_agg3: directed vectors with a queue scoreboard checked by an independent monitor
module tb_irq_agg3;
  typedef struct packed {
    logic       y;
    logic [1:0] id;
    logic [1:0] lost;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  exp_t  q[$];
  string qn[$];
  int total = 0;
  int bad = 0;
  event chk_now;
  irq_agg3_if #(.CNT_W(2)) bus();
  irq_agg3 #(.CNT_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic [2:0] abc, input logic [2:0] m, input logic rdy,
                      input logic ey, input logic [1:0] eid, input logic [1:0] el, input string nm);
    @(negedge clk);
    rst_n = r;
    {bus.c, bus.b, bus.a} = abc;
    bus.mask = m;
    bus.out_ready = rdy;
    q.push_back('{y: ey, id: eid, lost: el});
    qn.push_back(nm);
  endtask
  task automatic reset_now();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    q.push_back('{y: 1'b0, id: 2'd3, lost: 2'd0});
    qn.push_back("rst_async");
    ->chk_now;
  endtask
  initial begin
    exp_t e;
    string nm;
    forever begin
      @(posedge clk or chk_now);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        nm = qn.pop_front();
        total++;
        if (bus.y !== e.y || bus.out_valid !== e.y || bus.out_id !== e.id || bus.lost_cnt !== e.lost) begin
          bad++;
          $display("FAIL %s: got y=%b valid=%b id=%0d lost=%0d, want y=%b valid=%b id=%0d lost=%0d",
                   nm, bus.y, bus.out_valid, bus.out_id, bus.lost_cnt, e.y, e.y, e.id, e.lost);
        end
      end
    end
  end
  initial begin
    rst_n = 1'b0;
    {bus.c, bus.b, bus.a} = 3'b001;
    bus.mask = 3'b000;
    bus.out_ready = 1'b0;
    step(0, 3'b001, 3'b000, 0, 0, 3, 0, "reset");
    step(1, 3'b001, 3'b000, 0, 0, 3, 0, "hold_high");
    step(1, 3'b000, 3'b000, 0, 0, 3, 0, "a_low");
    step(1, 3'b001, 3'b000, 0, 1, 0, 0, "a_rise");
    step(1, 3'b001, 3'b000, 1, 0, 3, 0, "a_ack");
    step(1, 3'b001, 3'b000, 0, 0, 3, 0, "a_level_once");
    step(1, 3'b000, 3'b000, 0, 0, 3, 0, "all_low");
    step(1, 3'b111, 3'b000, 1, 1, 0, 0, "all_rise");
    step(1, 3'b111, 3'b000, 1, 1, 1, 0, "id_b");
    step(1, 3'b111, 3'b000, 1, 1, 2, 0, "id_c");
    step(1, 3'b111, 3'b000, 1, 0, 3, 0, "drained");
    step(1, 3'b000, 3'b000, 0, 0, 3, 0, "idle");
    step(1, 3'b010, 3'b000, 0, 1, 1, 0, "b_set");
    step(1, 3'b000, 3'b000, 0, 1, 1, 0, "b_hold");
    step(1, 3'b010, 3'b000, 0, 1, 1, 1, "b_lost1");
    step(1, 3'b000, 3'b000, 0, 1, 1, 1, "b_hold2");
    step(1, 3'b010, 3'b000, 0, 1, 1, 2, "b_lost2");
    step(1, 3'b000, 3'b000, 1, 0, 3, 2, "b_ack");
    step(1, 3'b100, 3'b000, 0, 1, 2, 2, "c_set");
    step(1, 3'b000, 3'b000, 0, 1, 2, 2, "c_hold");
    step(1, 3'b100, 3'b000, 1, 1, 2, 2, "c_set_wins");
    step(1, 3'b100, 3'b000, 0, 1, 2, 2, "c_still");
    step(1, 3'b000, 3'b000, 1, 0, 3, 2, "c_ack");
    step(1, 3'b001, 3'b000, 0, 1, 0, 2, "a_set");
    step(1, 3'b000, 3'b000, 0, 1, 0, 2, "a_hold");
    step(1, 3'b001, 3'b000, 0, 1, 0, 3, "a_lost");
    step(1, 3'b000, 3'b000, 0, 1, 0, 3, "a_hold2");
    step(1, 3'b001, 3'b000, 0, 1, 0, 3, "sat1");
    step(1, 3'b000, 3'b000, 0, 1, 0, 3, "a_hold3");
    step(1, 3'b001, 3'b000, 0, 1, 0, 3, "sat2");
    step(1, 3'b000, 3'b000, 1, 0, 3, 3, "a_ack2");
    step(1, 3'b001, 3'b001, 0, 0, 3, 3, "masked_a");
    step(1, 3'b000, 3'b001, 0, 0, 3, 3, "masked_hold");
    step(1, 3'b000, 3'b000, 0, 1, 0, 3, "unmask_a");
    step(1, 3'b010, 3'b000, 0, 1, 0, 3, "a_b_pending");
    reset_now();
    step(0, 3'b000, 3'b000, 0, 0, 3, 0, "in_reset");
    step(1, 3'b000, 3'b000, 0, 0, 3, 0, "after_reset");
    step(1, 3'b110, 3'b000, 0, 1, 1, 0, "bc_set");
    step(1, 3'b000, 3'b000, 0, 1, 1, 0, "bc_hold");
    step(1, 3'b111, 3'b000, 0, 1, 0, 2, "multi_lost");
    step(1, 3'b000, 3'b000, 1, 1, 1, 2, "a_ack3");
    step(1, 3'b000, 3'b010, 0, 1, 2, 2, "mask_b");
    step(1, 3'b010, 3'b010, 0, 1, 2, 3, "masked_lost");
    step(1, 3'b000, 3'b000, 0, 1, 1, 3, "unmask_preempt");
    for (int k = 0; k < 5 && q.size() != 0; k++) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
